// File: rtl/if_id_fetch_stage.sv
// RV32I instruction fetch over a req/ack memory port, plus the IF/ID pipeline register.
// Latency: an instruction reaches ID one edge after its ack; one per cycle when ack is same-cycle.
// Backpressure: load hazard holds ID and parks one fetched word; branch hazard flushes ID and redirects.
module if_id_fetch_stage #(
   parameter int                  NB_ADDR   = 32,
   parameter int                  NB_INSTR  = 32,
   parameter logic [NB_ADDR-1:0]  RESET_PC  = '0,
   parameter logic [NB_INSTR-1:0] NOP_INSTR = NB_INSTR'(32'h0000_0013)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_load_hazard,
   input  logic                i_branch_hazard,
   input  logic [NB_ADDR-1:0]  i_branch_target,
   output logic                o_imem_req,
   output logic [NB_ADDR-1:0]  o_imem_addr,
   input  logic                i_imem_ack,
   input  logic [NB_INSTR-1:0] i_imem_rdata,
   output logic                o_id_valid,
   output logic [NB_ADDR-1:0]  o_id_pc,
   output logic [NB_INSTR-1:0] o_id_instr
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_FETCH,
      ST_DRAIN,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic [NB_ADDR-1:0]  pc;
      logic [NB_INSTR-1:0] instr;
   } slot_t;

   localparam logic [NB_ADDR-1:0] ALIGN_MASK = {{(NB_ADDR-2){1'b1}}, 2'b00};

   state_t             state, state_nxt;
   logic [NB_ADDR-1:0] pc, pc_nxt;
   logic [NB_ADDR-1:0] tgt, tgt_nxt;
   slot_t              hold_buf, hold_buf_nxt;
   logic               id_vld, id_vld_nxt;
   slot_t              id_q, id_nxt;
   logic               id_flush;

   logic [NB_ADDR-1:0] target_al;
   logic [NB_ADDR-1:0] pc_inc;

   assign target_al = i_branch_target & ALIGN_MASK;
   assign pc_inc    = pc + NB_ADDR'(4);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_BOOT;
         pc       <= RESET_PC;
         tgt      <= '0;
         hold_buf <= '0;
         id_vld   <= 1'b0;
         id_q     <= '{pc: '0, instr: NOP_INSTR};
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         tgt      <= tgt_nxt;
         hold_buf <= hold_buf_nxt;
         id_vld   <= id_vld_nxt;
         id_q     <= id_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      tgt_nxt      = tgt;
      hold_buf_nxt = hold_buf;
      id_vld_nxt   = id_vld;
      id_nxt       = id_q;
      id_flush     = 1'b0;

      case (state)
         ST_BOOT: begin
            state_nxt = ST_FETCH;
         end

         ST_FETCH: begin
            if (i_branch_hazard) begin
               id_flush = 1'b1;
               if (i_imem_ack) begin
                  pc_nxt = target_al;
               end else begin
                  tgt_nxt   = target_al;
                  state_nxt = ST_DRAIN;
               end
            end else if (i_imem_ack) begin
               pc_nxt = pc_inc;
               if (i_load_hazard) begin
                  hold_buf_nxt = '{pc: pc, instr: i_imem_rdata};
                  state_nxt    = ST_HOLD;
               end else begin
                  id_vld_nxt = 1'b1;
                  id_nxt     = '{pc: pc, instr: i_imem_rdata};
               end
            end else if (!i_load_hazard) begin
               id_flush = 1'b1;
            end
         end

         // Address must stay put until the in-flight request acks; its data is stale.
         ST_DRAIN: begin
            if (i_branch_hazard) begin
               tgt_nxt = target_al;
            end
            if (i_imem_ack) begin
               pc_nxt    = i_branch_hazard ? target_al : tgt;
               state_nxt = ST_FETCH;
            end
            if (i_branch_hazard || !i_load_hazard) begin
               id_flush = 1'b1;
            end
         end

         ST_HOLD: begin
            if (i_branch_hazard) begin
               id_flush  = 1'b1;
               pc_nxt    = target_al;
               state_nxt = ST_FETCH;
            end else if (!i_load_hazard) begin
               id_vld_nxt = 1'b1;
               id_nxt     = hold_buf;
               state_nxt  = ST_FETCH;
            end
         end

         default: begin
            state_nxt = ST_BOOT;
         end
      endcase

      // Bubble keeps the previous pc; only valid and instr are meaningful.
      if (id_flush) begin
         id_vld_nxt   = 1'b0;
         id_nxt.instr = NOP_INSTR;
      end
   end

   assign o_imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
   assign o_imem_addr = pc;
   assign o_id_valid  = id_vld;
   assign o_id_pc     = id_q.pc;
   assign o_id_instr  = id_q.instr;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: boot, load stall, branch drain, flush in hold, pc wrap, reset mid-request.
module tb_if_id_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'h1000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_load_hazard;
   logic        i_branch_hazard;
   logic [31:0] i_branch_target;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic        o_id_valid;
   logic [31:0] o_id_pc;
   logic [31:0] o_id_instr;

   logic        req2;
   logic [31:0] addr2;
   logic [31:0] rdata2;
   logic        id_valid2;
   logic [31:0] id_pc2;
   logic [31:0] id_instr2;

   int n_run  = 0;
   int n_fail = 0;

   always #5 i_clk = ~i_clk;

   // Memory returns a word derived from the address so instr and pc differ.
   assign i_imem_rdata = o_imem_addr ^ KEY;
   assign rdata2       = addr2;

   if_id_fetch_stage dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_load_hazard   (i_load_hazard),
      .i_branch_hazard (i_branch_hazard),
      .i_branch_target (i_branch_target),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_ack      (i_imem_ack),
      .i_imem_rdata    (i_imem_rdata),
      .o_id_valid      (o_id_valid),
      .o_id_pc         (o_id_pc),
      .o_id_instr      (o_id_instr)
   );

   if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_load_hazard   (1'b0),
      .i_branch_hazard (1'b0),
      .i_branch_target (32'h0),
      .o_imem_req      (req2),
      .o_imem_addr     (addr2),
      .i_imem_ack      (1'b1),
      .i_imem_rdata    (rdata2),
      .o_id_valid      (id_valid2),
      .o_id_pc         (id_pc2),
      .o_id_instr      (id_instr2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst_n         = 1'b0;
      i_load_hazard   = 1'b0;
      i_branch_hazard = 1'b0;
      i_branch_target = 32'h0;
      i_imem_ack      = 1'b1;

      // reset state
      tick();
      tick();
      check("rst_req",   32'(o_imem_req), 32'd0);
      check("rst_valid", 32'(o_id_valid), 32'd0);
      check("rst_idpc",  o_id_pc,        32'h0);
      check("rst_instr", o_id_instr,     NOP);
      check("rst_addr",  o_imem_addr,    32'h0);
      i_rst_n = 1'b1;

      // boot then back-to-back fetch with ack tied high
      tick();
      check("boot_req",   32'(o_imem_req), 32'd1);
      check("boot_addr",  o_imem_addr,    32'h0);
      check("wrap_addr0", addr2,          32'hFFFF_FFFC);
      tick();
      check("f0_valid", 32'(o_id_valid), 32'd1);
      check("f0_pc",    o_id_pc,        32'h0);
      check("f0_instr", o_id_instr,     32'h1000_0000);
      check("f0_addr",  o_imem_addr,    32'h4);
      check("wrap_addr1", addr2,        32'h0);
      check("wrap_idpc",  id_pc2,       32'hFFFF_FFFC);
      tick();
      check("f1_pc", o_id_pc, 32'h4);
      tick();
      check("f2_pc",    o_id_pc,     32'h8);
      check("f2_instr", o_id_instr,  32'h1000_0008);
      check("f2_addr",  o_imem_addr, 32'hC);

      // load hazard for two cycles: 8 held, C parked in the buffer
      i_load_hazard = 1'b1;
      tick();
      check("ld1_req", 32'(o_imem_req), 32'd0);
      check("ld1_pc",  o_id_pc,        32'h8);
      tick();
      check("ld2_req",   32'(o_imem_req), 32'd0);
      check("ld2_pc",    o_id_pc,        32'h8);
      check("ld2_valid", 32'(o_id_valid), 32'd1);
      i_load_hazard = 1'b0;
      tick();
      check("ld_rel_pc",    o_id_pc,        32'hC);
      check("ld_rel_instr", o_id_instr,     32'h1000_000C);
      check("ld_rel_req",   32'(o_imem_req), 32'd1);
      check("ld_rel_addr",  o_imem_addr,    32'h10);

      // slow memory; branch to 0x100 while a request is outstanding
      i_imem_ack = 1'b0;
      tick();
      check("w1_valid", 32'(o_id_valid), 32'd0);
      check("w1_instr", o_id_instr,     NOP);
      i_branch_hazard = 1'b1;
      i_branch_target = 32'h100;
      tick();
      i_branch_hazard = 1'b0;
      check("dr1_addr", o_imem_addr,    32'h10);
      check("dr1_req",  32'(o_imem_req), 32'd1);
      tick();
      check("dr2_addr",  o_imem_addr,    32'h10);
      check("dr2_valid", 32'(o_id_valid), 32'd0);
      i_imem_ack = 1'b1;
      tick();
      check("redir_addr",  o_imem_addr,    32'h100);
      check("redir_valid", 32'(o_id_valid), 32'd0);
      check("redir_instr", o_id_instr,     NOP);
      tick();
      check("tgt_pc",    o_id_pc,        32'h100);
      check("tgt_valid", 32'(o_id_valid), 32'd1);

      // enter HOLD, then branch and load together with a misaligned target
      i_load_hazard = 1'b1;
      tick();
      check("h_req", 32'(o_imem_req), 32'd0);
      check("h_pc",  o_id_pc,        32'h100);
      i_branch_hazard = 1'b1;
      i_branch_target = 32'h203;
      tick();
      i_branch_hazard = 1'b0;
      i_load_hazard   = 1'b0;
      check("hb_valid", 32'(o_id_valid), 32'd0);
      check("hb_instr", o_id_instr,     NOP);
      check("hb_addr",  o_imem_addr,    32'h200);
      check("hb_req",   32'(o_imem_req), 32'd1);
      tick();
      check("hb_next_pc",    o_id_pc,        32'h200);
      check("hb_next_instr", o_id_instr,     32'h1000_0200);

      // reset asserted while draining
      i_imem_ack      = 1'b0;
      i_branch_hazard = 1'b1;
      i_branch_target = 32'h300;
      tick();
      i_branch_hazard = 1'b0;
      check("pre_rst_req",  32'(o_imem_req), 32'd1);
      check("pre_rst_addr", o_imem_addr,    32'h204);
      #2 i_rst_n = 1'b0;
      #1;
      check("mid_rst_req",   32'(o_imem_req), 32'd0);
      check("mid_rst_valid", 32'(o_id_valid), 32'd0);
      check("mid_rst_addr",  o_imem_addr,    32'h0);
      #2 i_rst_n = 1'b1;
      i_imem_ack = 1'b1;
      tick();
      check("rb_req",  32'(o_imem_req), 32'd1);
      check("rb_addr", o_imem_addr,    32'h0);
      tick();
      check("rb_pc",    o_id_pc,        32'h0);
      check("rb_valid", 32'(o_id_valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
